// File: rtl/halt_retire.sv
// halt_retire: writeback-side retirement monitor.
// Shadows the architectural return register, counts retired instructions,
// and on a retiring halt squashes younger writebacks, waits out a drain
// window and then raises isHalt with the frozen return value.
// Optional feature macro: HALT_ON_EXC_EN (adds wb_exc; a faulting retirement
// halts the program and reports EXC_RET as the return value).
module halt_retire #(
  parameter logic [4:0]  RET_REG      = 5'd1,
  parameter int unsigned DRAIN_CYCLES = 3
`ifdef HALT_ON_EXC_EN
  ,
  parameter logic [31:0] EXC_RET      = 32'hDEAD_BEEF
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic        wb_is_halt,
  input  logic        wb_rd_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
`ifdef HALT_ON_EXC_EN
  input  logic        wb_exc,
`endif
  output logic        squash,
  output logic        isHalt,
  output logic [31:0] ret_val,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Counter is loaded with DRAIN_CYCLES-1 so HALTED is reached exactly
  // DRAIN_CYCLES edges after the halt retires.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_drain_cnt;
  logic [31:0] r_ret_val;
  logic [31:0] r_retired_count;
  logic        r_squash;
  logic        r_is_halt;

  state_t      w_state_nxt;
  logic [3:0]  w_drain_cnt_nxt;
  logic [31:0] w_ret_val_nxt;
  logic [31:0] w_retired_count_nxt;
  logic        w_ret_wr;
  logic        w_halt_ev;

  // Decode a write to the reported register (r0 can never be written).
  always_comb begin
    w_ret_wr = 1'b0;
    if (wb_rd_we && (wb_rd == RET_REG) && (wb_rd != 5'd0)) begin
      w_ret_wr = 1'b1;
    end else begin
      w_ret_wr = 1'b0;
    end
  end

  // A retirement ends the program on a halt, or on a fault when enabled.
  always_comb begin
    w_halt_ev = wb_is_halt;
`ifdef HALT_ON_EXC_EN
    if (wb_exc) begin
      w_halt_ev = 1'b1;
    end else begin
      w_halt_ev = wb_is_halt;
    end
`endif
  end

  // Next-state, shadow register and retirement counter logic.
  always_comb begin
    w_state_nxt         = r_state;
    w_drain_cnt_nxt     = r_drain_cnt;
    w_ret_val_nxt       = r_ret_val;
    w_retired_count_nxt = r_retired_count;
    case (r_state)
      ST_RUN: begin
        if (wb_valid) begin
          if (r_retired_count != 32'hFFFF_FFFF) begin
            w_retired_count_nxt = r_retired_count + 32'd1;
          end else begin
            w_retired_count_nxt = r_retired_count;
          end
          // The halting instruction's own write still lands before the freeze.
          if (w_ret_wr) begin
            w_ret_val_nxt = wb_data;
          end else begin
            w_ret_val_nxt = r_ret_val;
          end
`ifdef HALT_ON_EXC_EN
          // A fault reports the exception code, overriding any same-cycle write.
          if (wb_exc) begin
            w_ret_val_nxt = EXC_RET;
          end else begin
            w_ret_val_nxt = w_ret_val_nxt;
          end
`endif
          if (w_halt_ev) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = DRAIN_INIT;
          end else begin
            w_state_nxt     = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Writebacks are ignored here; only the drain window advances.
        if (r_drain_cnt == 4'd0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 4'd1;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_drain_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_drain_cnt     <= 4'd0;
      r_ret_val       <= 32'd0;
      r_retired_count <= 32'd0;
      r_squash        <= 1'b0;
      r_is_halt       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_drain_cnt     <= w_drain_cnt_nxt;
      r_ret_val       <= w_ret_val_nxt;
      r_retired_count <= w_retired_count_nxt;
      r_squash        <= (w_state_nxt != ST_RUN);
      r_is_halt       <= (w_state_nxt == ST_HALTED);
    end
  end

  assign squash        = r_squash;
  assign isHalt        = r_is_halt;
  assign ret_val       = r_ret_val;
  assign retired_count = r_retired_count;

endmodule

// File: tb/tb_halt_retire.sv
// Self-checking bench for halt_retire: directed scenarios plus randomized
// programs, compared every cycle against a program-level reference model.
module tb_halt_retire;

  localparam int          DRAIN   = 3;
  localparam logic [4:0]  RET     = 5'd1;
  localparam logic [31:0] EXC_VAL = 32'hDEAD_BEEF;
`ifdef HALT_ON_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_is_halt, wb_rd_we, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        squash, isHalt;
  logic [31:0] ret_val, retired_count;

  int checks = 0;
  int errors = 0;

  // Reference model: program-level view of the retirement stream.
  bit          m_halted;      // a halting retirement has happened
  int          m_edge;        // clock edges since reset
  int          m_halt_edge;   // edge at which the halt retired
  logic [31:0] m_ret;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  halt_retire dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_is_halt   (wb_is_halt),
    .wb_rd_we     (wb_rd_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
`ifdef HALT_ON_EXC_EN
    .wb_exc       (wb_exc),
`endif
    .squash       (squash),
    .isHalt       (isHalt),
    .ret_val      (ret_val),
    .retired_count(retired_count)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every edge, reset asynchronously.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_halted = 1'b0; m_edge = 0; m_halt_edge = 0; m_ret = 32'd0; m_cnt = 32'd0;
      end else begin
        m_edge++;
        if (!m_halted && wb_valid) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          if (wb_rd_we && wb_rd == RET && RET != 5'd0) m_ret = wb_data;
          if (EXC_EN && wb_exc) m_ret = EXC_VAL;
          if (wb_is_halt || (EXC_EN && wb_exc)) begin
            m_halted    = 1'b1;
            m_halt_edge = m_edge;
          end
        end
      end
    end
  end

  // Compare process: every negedge, DUT outputs vs. model.
  initial begin
    forever begin
      @(negedge clk);
      check32("cmp_squash", {31'd0, squash}, {31'd0, m_halted});
      check32("cmp_isHalt", {31'd0, isHalt},
              {31'd0, (m_halted && (m_edge - m_halt_edge >= DRAIN))});
      check32("cmp_ret_val", ret_val, m_ret);
      check32("cmp_retired_count", retired_count, m_cnt);
    end
  end

  task automatic step(input logic v, input logic h, input logic we,
                      input logic [4:0] rd, input logic [31:0] d, input logic e);
    @(negedge clk); #1;
    wb_valid = v; wb_is_halt = h; wb_rd_we = we; wb_rd = rd; wb_data = d; wb_exc = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_is_halt = 1'b0; wb_rd_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; wb_exc = 1'b0;
    @(negedge clk); #1;
    if (chk) begin
      check32("rst_squash", {31'd0, squash}, 32'd0);
      check32("rst_isHalt", {31'd0, isHalt}, 32'd0);
      check32("rst_ret_val", ret_val, 32'd0);
      check32("rst_count", retired_count, 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_is_halt = 1'b0; wb_rd_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; wb_exc = 1'b0;

    // 1) four ALU ops then a halt; r1 last written 0x2A
    do_reset(1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_002A, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0005, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd1, 32'h0000_0077, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0009, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(1);
    check32("t1_squash_in_drain", {31'd0, squash}, 32'd1);
    idle(2);
    check32("t1_isHalt_before", {31'd0, isHalt}, 32'd0);
    idle(1);
    check32("t1_isHalt_after", {31'd0, isHalt}, 32'd1);
    check32("t1_ret_val", ret_val, 32'h0000_002A);
    check32("t1_count", retired_count, 32'd5);

    // 2) halt writes r1 itself; 3) retirements during drain are ignored
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0011, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd1, 32'h1234_5678, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF, 1'b0);
    check32("t3_squash", {31'd0, squash}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'hFFFF_FFFF, 1'b0);
    idle(3);
    check32("t2_ret_val", ret_val, 32'h1234_5678);
    check32("t3_count", retired_count, 32'd2);
    check32("t3_isHalt", {31'd0, isHalt}, 32'd1);

    // 4) reset in the middle of drain, then a fresh program returning 7
    do_reset(1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(1);
    check32("t4_squash_pre", {31'd0, squash}, 32'd1);
    do_reset(1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'd7, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(4);
    check32("t4_ret_val", ret_val, 32'd7);
    check32("t4_isHalt", {31'd0, isHalt}, 32'd1);
    check32("t4_count", retired_count, 32'd2);

    // 5) counter saturation after preloading near the top
    do_reset(1'b0);
    idle(1);
    force dut.r_retired_count = 32'hFFFF_FFFD;
    m_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_retired_count;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(1);
    check32("t5_saturate", retired_count, 32'hFFFF_FFFF);

    // 6) faulting retirement writing r1=5
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0005, 1'b1);
    idle(4);
    check32("t6_count", retired_count, 32'd1);
    if (EXC_EN) begin
      check32("t6_ret_val", ret_val, 32'hDEAD_BEEF);
      check32("t6_isHalt", {31'd0, isHalt}, 32'd1);
    end else begin
      check32("t6_ret_val", ret_val, 32'h0000_0005);
      check32("t6_isHalt", {31'd0, isHalt}, 32'd0);
    end

    // RET_REG=0 style write to r0 never reaches ret_val
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd0, 32'hCAFE_F00D, 1'b0);
    idle(1);
    check32("r0_write_ignored", ret_val, 32'd0);

    // Randomized programs checked every cycle by the compare process
    for (int p = 0; p < 25; p++) begin
      do_reset(1'b0);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 99) == 0) begin
          do_reset(1'b0);
        end else begin
          step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 39) == 0);
        end
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
